// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage forwarding muxes and load-use detection.
// Bubbles replace the captured instruction on flush or hazard; stall freezes everything.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] id_read_data_1,
  input  logic [DATA_W-1:0] id_read_data_2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [2:0]        id_alu_control,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              exmem_reg_write,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_W-1:0]  memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic [DATA_W-1:0] Read_data_1,
  output logic [DATA_W-1:0] Data_2,
  output logic [2:0]        ALU_control,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_W-1:0]  ex_dest_reg,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_valid,
  output logic              load_use_hazard
);

  typedef struct packed {
    logic [DATA_W-1:0] data_1;
    logic [DATA_W-1:0] data_2;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  dest;
    logic [2:0]        alu_control;
    logic              alu_src;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              valid;
  } idex_t;

  idex_t q, cap, nxt;

  always_comb begin
    cap             = '0;
    cap.data_1      = id_read_data_1;
    cap.data_2      = id_read_data_2;
    cap.imm         = id_imm;
    cap.rs          = id_rs;
    cap.rt          = id_rt;
    cap.dest        = id_reg_dst ? id_rd : id_rt;
    cap.alu_control = id_alu_control;
    cap.alu_src     = id_alu_src;
    cap.reg_write   = id_reg_write;
    cap.mem_read    = id_mem_read;
    cap.mem_write   = id_mem_write;
    cap.mem_to_reg  = id_mem_to_reg;
    cap.valid       = 1'b1;
  end

  assign load_use_hazard = q.valid & q.mem_read & (q.rt != '0) &
                           ((q.rt == id_rs) | (q.rt == id_rt));

  // A bubble is an all-zero record, so flush and hazard together still give one bubble.
  assign nxt = (flush | load_use_hazard) ? idex_t'('0) : cap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      q <= '0;
    else if (!stall) q <= nxt;
  end

  // EX/MEM is the younger producer, so it is checked first; r0 never forwards.
  function automatic logic [DATA_W-1:0] fwd(input logic [REG_W-1:0]  src,
                                            input logic [DATA_W-1:0] reg_val,
                                            input logic              em_we,
                                            input logic [REG_W-1:0]  em_rd,
                                            input logic [DATA_W-1:0] em_val,
                                            input logic              mw_we,
                                            input logic [REG_W-1:0]  mw_rd,
                                            input logic [DATA_W-1:0] mw_val);
    if (em_we && em_rd != '0 && em_rd == src)      return em_val;
    else if (mw_we && mw_rd != '0 && mw_rd == src) return mw_val;
    else                                           return reg_val;
  endfunction

  logic [DATA_W-1:0] fwd_rt;

  assign Read_data_1   = fwd(q.rs, q.data_1, exmem_reg_write, exmem_rd, exmem_result,
                             memwb_reg_write, memwb_rd, memwb_data);
  assign fwd_rt        = fwd(q.rt, q.data_2, exmem_reg_write, exmem_rd, exmem_result,
                             memwb_reg_write, memwb_rd, memwb_data);
  assign ex_store_data = fwd_rt;
  assign Data_2        = q.alu_src ? q.imm : fwd_rt;
  assign ALU_control   = q.alu_control;
  assign ex_dest_reg   = q.dest;
  assign ex_reg_write  = q.reg_write;
  assign ex_mem_read   = q.mem_read;
  assign ex_mem_write  = q.mem_write;
  assign ex_mem_to_reg = q.mem_to_reg;
  assign ex_valid      = q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, operand select, forwarding priority,
// load-use bubbles, stall/flush priority and destination select.
module tb_id_ex_stage;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [DATA_W-1:0] id_read_data_1 = '0, id_read_data_2 = '0, id_imm = '0;
  logic [REG_W-1:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic [2:0]        id_alu_control = '0;
  logic id_alu_src = 0, id_reg_dst = 0, id_reg_write = 0, id_mem_read = 0;
  logic id_mem_write = 0, id_mem_to_reg = 0;
  logic exmem_reg_write = 0, memwb_reg_write = 0;
  logic [REG_W-1:0]  exmem_rd = '0, memwb_rd = '0;
  logic [DATA_W-1:0] exmem_result = '0, memwb_data = '0;
  logic [DATA_W-1:0] Read_data_1, Data_2, ex_store_data;
  logic [2:0]        ALU_control;
  logic [REG_W-1:0]  ex_dest_reg;
  logic ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_valid, load_use_hazard;

  int n_chk = 0, n_fail = 0;

  id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_read_data_1(id_read_data_1), .id_read_data_2(id_read_data_2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_control(id_alu_control),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .Read_data_1(Read_data_1), .Data_2(Data_2), .ALU_control(ALU_control),
    .ex_store_data(ex_store_data), .ex_dest_reg(ex_dest_reg),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_valid(ex_valid), .load_use_hazard(load_use_hazard)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait for the next rising edge, then settle 1 time unit before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [2:0] alu, input logic src, input logic dst,
                        input logic rw, input logic mr, input logic mw, input logic m2r);
    id_read_data_1 = d1; id_read_data_2 = d2; id_imm = imm;
    id_rs = rs; id_rt = rt; id_rd = rd; id_alu_control = alu;
    id_alu_src = src; id_reg_dst = dst; id_reg_write = rw;
    id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_rd1", Read_data_1, 0);
    chk("rst_d2", Data_2, 0);
    chk("rst_alu", {29'd0, ALU_control}, 0);
    chk("rst_valid", {31'd0, ex_valid}, 0);
    chk("rst_haz", {31'd0, load_use_hazard}, 0);
    #2 rst_n = 1'b1;

    // Capture something, then reset asynchronously mid-stream
    set_id(32'hAA, 32'hBB, 0, 1, 2, 3, 3'd6, 0, 0, 1, 0, 1, 0);
    step();
    chk("pre_rst_rd1", Read_data_1, 32'hAA);
    chk("pre_rst_valid", {31'd0, ex_valid}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rd1", Read_data_1, 0);
    chk("async_rst_alu", {29'd0, ALU_control}, 0);
    chk("async_rst_valid", {31'd0, ex_valid}, 0);
    chk("async_rst_rw", {31'd0, ex_reg_write}, 0);
    chk("async_rst_mw", {31'd0, ex_mem_write}, 0);
    rst_n = 1'b1;

    // First capture after release
    set_id(5, 3, 0, 1, 2, 3, 3'd2, 0, 0, 1, 0, 0, 0);
    step();
    chk("cap_rd1", Read_data_1, 5);
    chk("cap_d2", Data_2, 3);
    chk("cap_alu", {29'd0, ALU_control}, 2);
    chk("cap_valid", {31'd0, ex_valid}, 1);
    chk("cap_dest_rt", {27'd0, ex_dest_reg}, 2);

    // Immediate select
    set_id(1, 9, 32'hFFFF_FFFC, 1, 2, 3, 3'd2, 1, 0, 1, 0, 0, 0);
    step();
    chk("imm_d2", Data_2, 32'hFFFF_FFFC);
    chk("imm_store", ex_store_data, 9);

    // Forwarding priority
    set_id(32'h100, 32'h200, 0, 4, 4, 5, 3'd2, 0, 1, 1, 0, 0, 0);
    step();
    exmem_reg_write = 1; exmem_rd = 4; exmem_result = 32'h11;
    memwb_reg_write = 1; memwb_rd = 4; memwb_data = 32'h22;
    #1;
    chk("fwd_em_rd1", Read_data_1, 32'h11);
    chk("fwd_em_d2", Data_2, 32'h11);
    chk("fwd_em_st", ex_store_data, 32'h11);
    exmem_reg_write = 0;
    #1;
    chk("fwd_mw_rd1", Read_data_1, 32'h22);
    chk("fwd_mw_d2", Data_2, 32'h22);
    exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0;
    #1;
    chk("fwd_r0_rd1", Read_data_1, 32'h100);
    chk("fwd_r0_d2", Data_2, 32'h200);
    exmem_reg_write = 0; memwb_reg_write = 0;

    // Load-use: LW rt=8 in EX, dependent instruction in ID
    set_id(32'h40, 0, 4, 1, 8, 0, 3'd2, 1, 0, 1, 1, 0, 1);
    step();
    chk("lw_memread", {31'd0, ex_mem_read}, 1);
    set_id(32'h77, 32'h33, 0, 8, 3, 9, 3'd2, 0, 1, 1, 0, 0, 0);
    #1;
    chk("lu_haz", {31'd0, load_use_hazard}, 1);
    step();
    chk("lu_bub_valid", {31'd0, ex_valid}, 0);
    chk("lu_bub_rw", {31'd0, ex_reg_write}, 0);
    chk("lu_haz_clr", {31'd0, load_use_hazard}, 0);
    step();
    chk("lu_cap_valid", {31'd0, ex_valid}, 1);
    chk("lu_cap_rd1", Read_data_1, 32'h77);
    chk("lu_cap_dest", {27'd0, ex_dest_reg}, 9);

    // Load to r0: no hazard
    set_id(32'h40, 0, 4, 1, 0, 0, 3'd2, 1, 0, 1, 1, 0, 1);
    step();
    set_id(32'h77, 32'h33, 0, 0, 0, 9, 3'd2, 0, 1, 1, 0, 0, 0);
    #1;
    chk("lu_r0_haz", {31'd0, load_use_hazard}, 0);
    step();
    chk("lu_r0_valid", {31'd0, ex_valid}, 1);

    // Stall overrides flush
    set_id(32'h55, 0, 0, 1, 2, 3, 3'd7, 0, 0, 1, 0, 0, 0);
    step();
    stall = 1; flush = 1;
    set_id(32'h66, 0, 0, 1, 2, 3, 3'd1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_rd1", Read_data_1, 32'h55);
      chk("stall_alu", {29'd0, ALU_control}, 7);
      chk("stall_valid", {31'd0, ex_valid}, 1);
    end
    stall = 0;
    step();
    chk("flush_valid", {31'd0, ex_valid}, 0);
    chk("flush_rd1", Read_data_1, 0);
    chk("flush_alu", {29'd0, ALU_control}, 0);
    chk("flush_rw", {31'd0, ex_reg_write}, 0);
    flush = 0;

    // Destination select
    set_id(0, 0, 0, 1, 7, 12, 3'd2, 0, 1, 1, 0, 0, 0);
    step();
    chk("dst_rd", {27'd0, ex_dest_reg}, 12);
    id_reg_dst = 0;
    step();
    chk("dst_rt", {27'd0, ex_dest_reg}, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and EX-stage operand selection for the 5-stage MIPS pipeline. Captures decoded instruction fields from ID each cycle and drives the ALU's two operands and its 3-bit `ALU_control`. Operands come from the register file values, the sign-extended immediate, or EX/MEM and MEM/WB forwarding. The block also detects load-use hazards and inserts bubbles on stall, flush or hazard.

## Interface
Parameters:
- `DATA_W`, 32, datapath width
- `REG_W`, 5, register-index width

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `stall`  in  1  hold ID/EX contents unchanged
- `flush`  in  1  load a bubble instead of ID contents (branch/jump squash)
- `id_read_data_1`, `id_read_data_2`  in  DATA_W  register-file values for rs, rt
- `id_imm`  in  DATA_W  sign-extended immediate
- `id_rs`, `id_rt`, `id_rd`  in  REG_W  instruction register fields
- `id_alu_control`  in  3  0=AND 1=OR 2=ADD 6=SUB 7=SLT
- `id_alu_src`  in  1  1: operand B = immediate
- `id_reg_dst`  in  1  1: destination = rd, 0: destination = rt
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg`  in  1 each  control bits
- `exmem_reg_write`  in  1; `exmem_rd`  in  REG_W; `exmem_result`  in  DATA_W  EX/MEM forward source
- `memwb_reg_write`  in  1; `memwb_rd`  in  REG_W; `memwb_data`  in  DATA_W  MEM/WB forward source
- `Read_data_1`  out  DATA_W  ALU operand A
- `Data_2`  out  DATA_W  ALU operand B
- `ALU_control`  out  3  registered ALU op
- `ex_store_data`  out  DATA_W  forwarded rt value, used as SW data
- `ex_dest_reg`  out  REG_W  selected destination register
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`, `ex_valid`  out  1 each
- `load_use_hazard`  out  1  request to the front end to freeze PC and IF/ID

## Operation
- Registered fields: data_1, data_2, imm, rs, rt, dest, alu_control, alu_src, and the four control bits plus valid.
- `dest` is resolved at capture: `id_reg_dst ? id_rd : id_rt`.
- Hazard detection, combinational from registered state: `load_use_hazard = ex_valid & ex_mem_read & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt)`.
- Per-edge update, in priority order:
  1. `!rst_n`: all registers are 0.
  2. `stall`: hold all registers. Stall overrides flush and hazard; the issuer keeps `flush` asserted until `stall` drops.
  3. `flush | load_use_hazard`: load a bubble. Every registered field becomes 0 (valid=0, all controls 0, ALU_control=0).
  4. Otherwise: capture the ID inputs with valid=1.
- Forwarding for operand source X (rs or rt), combinational:
  - If `exmem_reg_write & exmem_rd != 0 & exmem_rd == X`, use `exmem_result`.
  - Else if `memwb_reg_write & memwb_rd != 0 & memwb_rd == X`, use `memwb_data`.
  - Else use the registered value.
  - EX/MEM always wins when both sources match.
- Operand outputs:
  - `Read_data_1` = forwarded rs value.
  - `ex_store_data` = forwarded rt value.
  - `Data_2` = `alu_src ? imm : forwarded rt`.
- Register 0 is never forwarded; its value is the registered one (0 from the register file).
- Forwarding applies identically when `ex_valid=0`. A bubble's zero fields produce Result=0 harmlessly.

## Timing
- Latency: ID inputs appear on the registered outputs one cycle after capture.
- Forwarding muxes are zero-latency from the `exmem_*` and `memwb_*` inputs.
- Reset is asynchronous. Outputs are forced to their reset values immediately on `rst_n` falling; no clock is required.
- Reset values:
  - All outputs 0, including `ALU_control`=0 and `load_use_hazard`=0.
  - `Read_data_1`/`Data_2` are 0 unless forwarding inputs are active.
- Reset release: the first capture happens on the first rising edge with `rst_n`=1.
- Reset mid-operation discards the in-flight instruction with no partial state.
- `load_use_hazard` is high for exactly one cycle per load-use pair:
  - The bubble it causes clears `ex_mem_read`, which deasserts the hazard.
  - If `stall` is also high, the hazard stays asserted until stall drops.
- Simultaneous `flush` and `load_use_hazard`: single bubble; identical result.
- Width rules:
  - Comparisons use full REG_W.
  - Data paths are DATA_W with no extension inside the block; `id_imm` is already sign-extended.

## Test plan
- Reset: assert `rst_n`=0 mid-stream with non-zero ID inputs → all outputs 0 immediately. After release and one edge with `id_read_data_1`=5, `id_read_data_2`=3, `id_alu_control`=2, `alu_src`=0 → `Read_data_1`=5, `Data_2`=3, `ALU_control`=2, `ex_valid`=1.
- Immediate select: `id_alu_src`=1, `id_imm`=0xFFFFFFFC, `id_read_data_2`=9 → `Data_2`=0xFFFFFFFC; `ex_store_data`=9.
- Forward priority: ex_rs=ex_rt=4; `exmem_rd`=4 with `exmem_result`=0x11; `memwb_rd`=4 with `memwb_data`=0x22; both write enables set → both operands 0x11. Drop `exmem_reg_write` → both 0x22. Set `exmem_rd`=`memwb_rd`=0 → registered values used.
- Load-use: EX holds LW with rt=8; ID presents `id_rs`=8 → `load_use_hazard`=1 for one cycle. Next edge loads a bubble (`ex_valid`=0, `ex_reg_write`=0); the hazard then clears. Repeat with rt=0 → no hazard.
- Stall vs flush: hold `stall`=1 and `flush`=1 for 3 cycles → registers unchanged. Release `stall` with `flush`=1 → bubble on the next edge.
- Destination select: `id_reg_dst`=1, rd=12, rt=7 → `ex_dest_reg`=12. With `id_reg_dst`=0 → 7.
